uart_rx_frame_ctrl: RTL and testbench

Self-contained, parametrised UART receive controller for the processor UART subsystem. It replaces the fixed-format receiver FSM plus external sampler/checker blocks with a single block that has:
- runtime-selectable parity and stop-bit count
- per-frame latched configuration
- a one-entry output holding register with valid/ready handshake
- explicit error pulses for parity, framing and overrun

It sits between the pad-side `rx_in` line and the UART RX FIFO / register bank.

---
 rtl/uart_rx_frame_ctrl.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// UART receiver: start/data/parity/stop framing with per-frame latched config.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each bit midpoint.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      par_en,
  input  logic                      par_odd,
  input  logic                      two_stop,
  output logic [DATA_WIDTH-1:0]     rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      parity_error,
  output logic                      framing_error,
  output logic                      overrun_error,
  output logic                      busy
);

  localparam int PW = PRESCALE_WIDTH;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT
  } state_t;

  state_t state_q, state_d;

  logic                  rx_meta, rx_sync;
  logic [PW-1:0]         cnt_q, p_q, half, last_pt;
  logic                  par_en_q, par_odd_q, two_stop_q;
  logic [IW-1:0]         bit_idx_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_bit_q, stop_bad_q;
  logic                  bit_val, sample, bit_end;
  logic                  finish, stop_fail, par_fail;
  logic                  fe_d, pe_d, good_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
    end
  end

  assign half = p_q >> 1;

`ifdef UART_RX_MAJORITY_EN
  logic smp_a_q, smp_b_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smp_a_q <= 1'b1;
      smp_b_q <= 1'b1;
    end else begin
      if (cnt_q == half - PW'(1)) smp_a_q <= rx_sync;
      if (cnt_q == half)          smp_b_q <= rx_sync;
    end
  end

  assign last_pt = half + PW'(1);
  assign bit_val = (smp_a_q & smp_b_q) | (smp_a_q & rx_sync) |
                   (smp_b_q & rx_sync);
`else
  assign last_pt = half;
  assign bit_val = rx_sync;
`endif

  assign sample  = (cnt_q == last_pt);
  assign bit_end = (cnt_q == p_q - PW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (!rx_sync) state_d = S_START;
      S_START: begin
        if (sample && bit_val) state_d = S_IDLE;
        else if (bit_end)      state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end && bit_idx_q == IW'(DATA_WIDTH - 1))
          state_d = par_en_q ? S_PARITY : S_STOP1;
      end
      S_PARITY: if (bit_end) state_d = S_STOP1;
      S_STOP1: begin
        if (finish)                     state_d = stop_fail ? S_WAIT : S_IDLE;
        else if (bit_end && two_stop_q) state_d = S_STOP2;
      end
      S_STOP2:  if (finish) state_d = stop_fail ? S_WAIT : S_IDLE;
      S_WAIT:   if (rx_sync) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Frame verdict is formed on the final stop sample and registered.
  always_comb begin
    busy      = (state_q != S_IDLE);
    finish    = sample &&
                ((state_q == S_STOP1 && !two_stop_q) || state_q == S_STOP2);
    stop_fail = !bit_val || (state_q == S_STOP2 && stop_bad_q);
    par_fail  = par_en_q && ((^data_q ^ par_bit_q) != par_odd_q);
    fe_d      = finish && stop_fail;
    pe_d      = finish && !stop_fail && par_fail;
    good_d    = finish && !stop_fail && !par_fail;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      p_q           <= PW'(8);
      par_en_q      <= 1'b0;
      par_odd_q     <= 1'b0;
      two_stop_q    <= 1'b0;
      bit_idx_q     <= '0;
      data_q        <= '0;
      par_bit_q     <= 1'b0;
      stop_bad_q    <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      parity_error  <= pe_d;
      framing_error <= fe_d;
      overrun_error <= good_d && rx_valid && !rx_ready;

      if (state_q == S_IDLE) begin
        cnt_q <= '0;
        if (!rx_sync) begin
          p_q        <= (prescale < PW'(8)) ? PW'(8) : prescale;
          par_en_q   <= par_en;
          par_odd_q  <= par_odd;
          two_stop_q <= two_stop;
          bit_idx_q  <= '0;
          stop_bad_q <= 1'b0;
        end
      end else if (bit_end || state_d == S_IDLE || state_d == S_WAIT) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + PW'(1);
      end

      if (state_q == S_DATA) begin
        if (sample)  data_q[bit_idx_q] <= bit_val;
        if (bit_end) bit_idx_q <= bit_idx_q + IW'(1);
      end
      if (state_q == S_PARITY && sample) par_bit_q <= bit_val;
      if (state_q == S_STOP1 && sample)  stop_bad_q <= !bit_val;

      if (good_d && (!rx_valid || rx_ready)) begin
        rx_data  <= data_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: random frames against a frame-level model.
// Majority-vote glitch scenario runs when UART_RX_MAJORITY_EN is defined.
module tb_uart_rx_frame_ctrl;

  localparam int DW = 8;
  localparam int PW = 6;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          par_en, par_odd, two_stop;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_ready;
  logic          parity_error, framing_error, overrun_error, busy;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  uart_rx_frame_ctrl #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .rx_in(rx_in), .prescale(prescale),
    .par_en(par_en), .par_odd(par_odd), .two_stop(two_stop),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_error(parity_error), .framing_error(framing_error),
    .overrun_error(overrun_error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int eff_p(input int p);
    return (p < 8) ? 8 : p;
  endfunction

  // Cycles from driving the start bit to the registered verdict.
  function automatic int exp_lat(input int p, input bit pen, input bit two);
    int pp;
    pp = eff_p(p);
    return 4 + (1 + DW + int'(pen) + int'(two)) * pp + pp / 2 + MAJ;
  endfunction

  task automatic xfer(
    input  logic [DW-1:0] d, input int p, input bit pen, input bit podd,
    input  bit two, input bit flip_par, input bit [1:0] stop_v,
    input  int rdy_at, input int chg_bit, input int chg_p, input int gl_bit,
    output int lat, output bit pe, output bit fe, output bit oe,
    output bit ld, output logic [DW-1:0] dat);
    bit bits[$];
    int pp, t0, lim;
    logic par;
    pp  = eff_p(p);
    lim = exp_lat(p, pen, two) + 4;
    par = ^d ^ podd ^ flip_par;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(par);
    bits.push_back(stop_v[0]);
    if (two) bits.push_back(stop_v[1]);
    prescale = PW'(p);
    par_en = pen;
    par_odd = podd;
    two_stop = two;
    lat = -1; pe = 0; fe = 0; oe = 0; ld = 0; dat = '0;
    @(negedge clk);
    t0 = cyc;
    fork
      begin
        for (int k = 0; k < bits.size(); k++) begin
          for (int c = 0; c < pp; c++) begin
            if (k == chg_bit && c == 0) prescale = PW'(chg_p);
            rx_in = (k == gl_bit && c == pp / 2 + 1) ? ~bits[k] : bits[k];
            @(negedge clk);
          end
        end
        rx_in = 1'b1;
      end
      begin
        if (rdy_at >= 0) begin
          while (cyc < t0 + rdy_at) @(negedge clk);
          rx_ready = 1'b1;
          @(negedge clk);
          rx_ready = 1'b0;
        end
      end
      begin
        logic vp;
        logic [DW-1:0] dp;
        vp = rx_valid;
        dp = rx_data;
        for (int i = 0; i < lim && lat < 0; i++) begin
          @(negedge clk);
          if (parity_error || framing_error || overrun_error ||
              (rx_valid && (!vp || rx_data != dp))) begin
            lat = cyc - t0;
            pe  = parity_error;
            fe  = framing_error;
            oe  = overrun_error;
            ld  = rx_valid && (!vp || rx_data != dp);
            dat = rx_data;
          end
          vp = rx_valid;
          dp = rx_data;
        end
      end
    join
  endtask

  task automatic consume();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset_state();
    checks++;
    if ({rx_valid, rx_data, parity_error, framing_error, overrun_error, busy}
        !== '0) begin
      failures++;
      $display("FAIL reset_state got v=%b d=%h pe=%b fe=%b oe=%b busy=%b want all 0",
               rx_valid, rx_data, parity_error, framing_error, overrun_error, busy);
    end
  endtask

  task automatic test_nominal();
    int lat, e;
    bit pe, fe, oe, ld;
    logic [DW-1:0] dat;
    rx_ready = 1'b0;
    e = exp_lat(16, 0, 0);
    xfer(8'hA5, 16, 0, 0, 0, 0, 2'b11, -1, -1, 0, -1, lat, pe, fe, oe, ld, dat);
    checks++;
    if (lat !== e) begin
      failures++;
      $display("FAIL nominal_latency got %0d want %0d", lat, e);
    end
    checks++;
    if ({ld, pe, fe, oe} !== 4'b1000 || dat !== 8'hA5) begin
      failures++;
      $display("FAIL nominal_data got ld=%b pe=%b fe=%b oe=%b d=%h want 1000 a5",
               ld, pe, fe, oe, dat);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rx_valid !== 1'b1) begin
      failures++;
      $display("FAIL nominal_hold got v=%b want 1", rx_valid);
    end
    consume();
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL nominal_consume got v=%b want 0", rx_valid);
    end
  endtask

  task automatic test_parity();
    int lat;
    bit pe, fe, oe, ld;
    logic [DW-1:0] dat;
    rx_ready = 1'b0;
    xfer(8'h3C, 16, 1, 0, 0, 1, 2'b11, -1, -1, 0, -1, lat, pe, fe, oe, ld, dat);
    repeat (2) @(negedge clk);
    checks++;
    if ({pe, fe, oe, ld} !== 4'b1000 || lat !== exp_lat(16, 1, 0) ||
        rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL parity_bad got pe=%b fe=%b oe=%b ld=%b lat=%0d v=%b want 1000 lat=%0d v=0",
               pe, fe, oe, ld, lat, rx_valid, exp_lat(16, 1, 0));
    end
    xfer(8'h3C, 16, 1, 0, 0, 0, 2'b11, -1, -1, 0, -1, lat, pe, fe, oe, ld, dat);
    checks++;
    if ({pe, fe, oe, ld} !== 4'b0001 || dat !== 8'h3C) begin
      failures++;
      $display("FAIL parity_good got pe=%b fe=%b oe=%b ld=%b d=%h want 0001 3c",
               pe, fe, oe, ld, dat);
    end
    consume();
  endtask

  task automatic test_false_start();
    bit seen_busy, seen_pulse;
    int lat;
    bit pe, fe, oe, ld;
    logic [DW-1:0] dat;
    prescale = PW'(16);
    seen_busy = 0;
    seen_pulse = 0;
    @(negedge clk);
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1;
      if (parity_error || framing_error || overrun_error || rx_valid)
        seen_pulse = 1;
    end
    checks++;
    if (seen_busy !== 1'b1 || seen_pulse !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL false_start got seen_busy=%b pulse=%b busy=%b want 1 0 0",
               seen_busy, seen_pulse, busy);
    end
`ifdef UART_RX_MAJORITY_EN
    rx_ready = 1'b1;
    xfer(8'hF0, 16, 0, 0, 0, 0, 2'b11, -1, -1, 0, 2, lat, pe, fe, oe, ld, dat);
    checks++;
    if (ld !== 1'b1 || dat !== 8'hF0) begin
      failures++;
      $display("FAIL glitch_vote got ld=%b d=%h want 1 f0", ld, dat);
    end
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
`else
    lat = 0; pe = 0; fe = 0; oe = 0; ld = 0; dat = '0;
`endif
  endtask

  task automatic test_overrun();
    int lat, e;
    bit pe, fe, oe, ld;
    logic [DW-1:0] dat;
    rx_ready = 1'b0;
    e = exp_lat(16, 0, 0);
    xfer(8'h11, 16, 0, 0, 0, 0, 2'b11, -1, -1, 0, -1, lat, pe, fe, oe, ld, dat);
    checks++;
    if (ld !== 1'b1 || dat !== 8'h11) begin
      failures++;
      $display("FAIL overrun_first got ld=%b d=%h want 1 11", ld, dat);
    end
    xfer(8'h22, 16, 0, 0, 0, 0, 2'b11, -1, -1, 0, -1, lat, pe, fe, oe, ld, dat);
    checks++;
    if ({oe, pe, fe, ld} !== 4'b1000 || lat !== e || dat !== 8'h11 ||
        rx_valid !== 1'b1) begin
      failures++;
      $display("FAIL overrun_pulse got oe=%b pe=%b fe=%b ld=%b lat=%0d d=%h v=%b want 1000 %0d 11 1",
               oe, pe, fe, ld, lat, dat, rx_valid, e);
    end
    @(negedge clk);
    checks++;
    if (overrun_error !== 1'b0) begin
      failures++;
      $display("FAIL overrun_width got oe=%b want 0", overrun_error);
    end
    consume();
    xfer(8'h11, 16, 0, 0, 0, 0, 2'b11, -1, -1, 0, -1, lat, pe, fe, oe, ld, dat);
    xfer(8'h22, 16, 0, 0, 0, 0, 2'b11, e - 1, -1, 0, -1, lat, pe, fe, oe, ld, dat);
    @(negedge clk);
    checks++;
    if ({oe, ld} !== 2'b01 || dat !== 8'h22 || lat !== e || rx_valid !== 1'b1) begin
      failures++;
      $display("FAIL overrun_ready got oe=%b ld=%b d=%h lat=%0d v=%b want 0 1 22 %0d 1",
               oe, ld, dat, lat, rx_valid, e);
    end
    consume();
  endtask

  task automatic test_framing();
    int lat, nfe;
    bit pe, fe, oe, ld;
    logic [DW-1:0] dat;
    rx_ready = 1'b1;
    xfer(8'h81, 16, 0, 0, 1, 0, 2'b01, -1, -1, 0, -1, lat, pe, fe, oe, ld, dat);
    checks++;
    if ({fe, pe, oe, ld} !== 4'b1000 || lat !== exp_lat(16, 0, 1)) begin
      failures++;
      $display("FAIL framing_stop2 got fe=%b pe=%b oe=%b ld=%b lat=%0d want 1000 %0d",
               fe, pe, oe, ld, lat, exp_lat(16, 0, 1));
    end
    repeat (6) @(negedge clk);
    prescale = PW'(16);
    two_stop = 1'b0;
    par_en = 1'b0;
    nfe = 0;
    rx_in = 1'b0;
    for (int i = 0; i < 3 * 10 * 16; i++) begin
      @(negedge clk);
      if (framing_error) nfe++;
    end
    checks++;
    if (nfe !== 1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL break got fe_count=%0d busy=%b want 1 1", nfe, busy);
    end
    rx_in = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL break_release got busy=%b want 0", busy);
    end
    xfer(8'h5A, 16, 0, 0, 0, 0, 2'b11, -1, -1, 0, -1, lat, pe, fe, oe, ld, dat);
    checks++;
    if ({ld, fe} !== 2'b10 || dat !== 8'h5A) begin
      failures++;
      $display("FAIL break_next got ld=%b fe=%b d=%h want 1 0 5a", ld, fe, dat);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_reconfig();
    int lat;
    bit pe, fe, oe, ld;
    logic [DW-1:0] dat;
    rx_ready = 1'b0;
    xfer(8'h77, 16, 0, 0, 0, 0, 2'b11, -1, -1, 0, -1, lat, pe, fe, oe, ld, dat);
    @(negedge clk);
    rx_in = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rx_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset got busy=%b v=%b want 1 1", busy, rx_valid);
    end
    reset = 1'b1;
    rx_in = 1'b1;
    #1;
    checks++;
    if ({rx_valid, rx_data, parity_error, framing_error, overrun_error, busy}
        !== '0) begin
      failures++;
      $display("FAIL mid_reset got v=%b d=%h busy=%b want 0 00 0",
               rx_valid, rx_data, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    rx_ready = 1'b1;
    xfer(8'hC3, 16, 0, 0, 0, 0, 2'b11, -1, -1, 0, -1, lat, pe, fe, oe, ld, dat);
    checks++;
    if (ld !== 1'b1 || dat !== 8'hC3 || lat !== exp_lat(16, 0, 0)) begin
      failures++;
      $display("FAIL post_reset got ld=%b d=%h lat=%0d want 1 c3 %0d",
               ld, dat, lat, exp_lat(16, 0, 0));
    end
    repeat (4) @(negedge clk);
    xfer(8'h96, 16, 0, 0, 0, 0, 2'b11, -1, 3, 8, -1, lat, pe, fe, oe, ld, dat);
    checks++;
    if (ld !== 1'b1 || dat !== 8'h96 || lat !== exp_lat(16, 0, 0)) begin
      failures++;
      $display("FAIL reconfig got ld=%b d=%h lat=%0d want 1 96 %0d",
               ld, dat, lat, exp_lat(16, 0, 0));
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    int lat, p, e;
    bit pe, fe, oe, ld, pen, podd, two, flip, sbad, pbad;
    bit [1:0] sv;
    logic [DW-1:0] d, dat;
    rx_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      d    = DW'($urandom);
      p    = $urandom_range(4, 20);
      pen  = 1'($urandom);
      podd = 1'($urandom);
      two  = 1'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      sv   = 2'b11;
      if ($urandom_range(0, 4) == 0) sv[$urandom_range(0, 1)] = 1'b0;
      sbad = !sv[0] || (two && !sv[1]);
      pbad = pen && flip;
      e    = exp_lat(p, pen, two);
      xfer(d, p, pen, podd, two, flip, sv, -1, -1, 0, -1,
           lat, pe, fe, oe, ld, dat);
      checks++;
      if (lat !== e || fe !== sbad || pe !== (!sbad && pbad) || oe !== 1'b0 ||
          ld !== (!sbad && !pbad) || (ld && dat !== d)) begin
        failures++;
        $display("FAIL random_%0d p=%0d pen=%b odd=%b two=%b got lat=%0d pe=%b fe=%b oe=%b ld=%b d=%h want lat=%0d fe=%b pe=%b ld=%b d=%h",
                 n, p, pen, podd, two, lat, pe, fe, oe, ld, dat, e, sbad,
                 !sbad && pbad, !sbad && !pbad, d);
      end
      repeat (6) @(negedge clk);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rx_in = 1'b1;
    prescale = PW'(16);
    par_en = 1'b0;
    par_odd = 1'b0;
    two_stop = 1'b0;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset_state();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    test_nominal();
    test_parity();
    test_false_start();
    test_overrun();
    test_framing();
    test_reset_reconfig();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
